// File: rtl/fixed_point_unit_seq.sv
// rtl/fixed_point_unit_seq.sv - sequential signed fixed-point ADD/SUB/MUL/DIV and unsigned SQRT unit
// start/busy/done handshake; MUL, DIV and SQRT run as iterative multi-cycle engines.
module fixed_point_unit_seq #(
   parameter int WIDTH     = 32,
   parameter int FBITS     = 10,
   parameter int MUL_WIDTH = 16,
   parameter bit SATURATE  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       operation,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             error
);
   localparam int N  = WIDTH / MUL_WIDTH;
   localparam int DW = WIDTH + FBITS;
   localparam int SN = DW / 2;
   localparam int CW = $clog2(DW + 1);
   localparam logic [CW-1:0] MUL_LAST  = CW'(N * N);
   localparam logic [CW-1:0] DIV_LAST  = CW'(DW);
   localparam logic [CW-1:0] SQRT_LAST = CW'(SN - 1);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_SQRT = 3'b011;
   localparam logic [2:0] OP_DIV  = 3'b100;

   typedef enum logic [2:0] {IDLE, ARITH, MUL_PP, SQRT_IT, DIV_IT, FINISH} state_t;
   state_t state;

   logic [2:0]         op;
   logic [WIDTH-1:0]   a, b;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [DW-1:0]      dq;
   logic [WIDTH-1:0]   rem;
   logic [DW-1:0]      rad;
   logic [SN-1:0]      root;
   logic [SN+1:0]      srem;

   logic [WIDTH-1:0] in_a_mag, a_mag, b_mag;
   logic             neg;
   assign in_a_mag = operand_1[WIDTH-1] ? -operand_1 : operand_1;
   assign a_mag    = a[WIDTH-1] ? -a : a;
   assign b_mag    = b[WIDTH-1] ? -b : b;
   assign neg      = a[WIDTH-1] ^ b[WIDTH-1];

   logic [WIDTH:0] sum;
   assign sum = (op == OP_SUB) ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
                               : ({a[WIDTH-1], a} + {b[WIDTH-1], b});

   // Multiply: one chunk pair per cycle, a-chunk index varies fastest.
   logic [CW-1:0]          idx_a, idx_b;
   logic [MUL_WIDTH-1:0]   chunk_a, chunk_b;
   logic [2*MUL_WIDTH-1:0] prod_small;
   logic [2*WIDTH-1:0]     pp, mul_mag, mul_full;
   logic                   mul_ovf;
   assign idx_a      = cnt % CW'(N);
   assign idx_b      = cnt / CW'(N);
   assign chunk_a    = a_mag[idx_a*MUL_WIDTH +: MUL_WIDTH];
   assign chunk_b    = b_mag[idx_b*MUL_WIDTH +: MUL_WIDTH];
   assign prod_small = chunk_a * chunk_b;
   assign pp         = (2*WIDTH)'(prod_small) << ((idx_a + idx_b) * MUL_WIDTH);
   assign mul_mag    = acc >> FBITS;
   assign mul_full   = neg ? -mul_mag : mul_mag;
   assign mul_ovf    = mul_full[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_full[WIDTH-1]}};

   logic [WIDTH:0] div_trial;
   logic           div_ge;
   logic [DW:0]    div_full;
   logic           div_ovf;
   assign div_trial = {rem, dq[DW-1]};
   assign div_ge    = div_trial >= {1'b0, b_mag};
   assign div_full  = neg ? -{1'b0, dq} : {1'b0, dq};
   assign div_ovf   = div_full[DW:WIDTH-1] != {(DW-WIDTH+2){div_full[DW]}};

   // Square root: bring down two radicand bits, try subtracting 4*root+1.
   logic [SN+3:0] sq_trial_rem, sq_trial;
   logic          sq_ge;
   logic [SN-1:0] sq_root_next;
   assign sq_trial_rem = {srem, rad[DW-1:DW-2]};
   assign sq_trial     = (SN+4)'({root, 2'b01});
   assign sq_ge        = sq_trial_rem >= sq_trial;
   assign sq_root_next = {root[SN-2:0], sq_ge};

   logic             last;
   logic [WIDTH-1:0] fin_result;
   logic             fin_ovf, fin_err;
   always_comb begin
      fin_result = '0;
      fin_ovf    = 1'b0;
      fin_err    = 1'b0;
      last       = 1'b0;
      case (state)
         ARITH: begin
            last = 1'b1;
            if (op == OP_ADD || op == OP_SUB) begin
               fin_ovf    = sum[WIDTH] ^ sum[WIDTH-1];
               fin_result = (SATURATE && fin_ovf) ? (sum[WIDTH] ? MAX_NEG : MAX_POS) : sum[WIDTH-1:0];
            end else begin
               fin_err = 1'b1;
            end
         end
         MUL_PP: begin
            last       = (cnt == MUL_LAST);
            fin_ovf    = mul_ovf;
            fin_result = (SATURATE && mul_ovf) ? (neg ? MAX_NEG : MAX_POS) : mul_full[WIDTH-1:0];
         end
         DIV_IT: begin
            last = (cnt == DIV_LAST);
            if (b == '0) begin
               fin_err    = 1'b1;
               fin_result = SATURATE ? (a[WIDTH-1] ? MAX_NEG : MAX_POS) : '0;
            end else begin
               fin_ovf    = div_ovf;
               fin_result = (SATURATE && div_ovf) ? (neg ? MAX_NEG : MAX_POS) : div_full[WIDTH-1:0];
            end
         end
         SQRT_IT: begin
            last = (cnt == SQRT_LAST);
            if (a[WIDTH-1]) fin_err = 1'b1;
            else            fin_result = WIDTH'(sq_root_next);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         error    <= 1'b0;
         op       <= '0;
         a        <= '0;
         b        <= '0;
         cnt      <= '0;
         acc      <= '0;
         dq       <= '0;
         rem      <= '0;
         rad      <= '0;
         root     <= '0;
         srem     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, FINISH: begin
               state <= IDLE;
               if (start) begin
                  op   <= operation;
                  a    <= operand_1;
                  b    <= operand_2;
                  cnt  <= '0;
                  busy <= 1'b1;
                  acc  <= '0;
                  rem  <= '0;
                  dq   <= DW'(in_a_mag) << FBITS;
                  rad  <= DW'(operand_1) << FBITS;
                  root <= '0;
                  srem <= '0;
                  case (operation)
                     OP_MUL:  state <= MUL_PP;
                     OP_SQRT: state <= SQRT_IT;
                     OP_DIV:  state <= DIV_IT;
                     default: state <= ARITH;
                  endcase
               end
            end
            MUL_PP: begin
               acc <= acc + pp;
               cnt <= cnt + CW'(1);
            end
            DIV_IT: begin
               rem <= div_ge ? WIDTH'(div_trial - {1'b0, b_mag}) : WIDTH'(div_trial);
               dq  <= {dq[DW-2:0], div_ge};
               cnt <= cnt + CW'(1);
            end
            SQRT_IT: begin
               srem <= (SN+2)'(sq_ge ? sq_trial_rem - sq_trial : sq_trial_rem);
               root <= sq_root_next;
               rad  <= rad << 2;
               cnt  <= cnt + CW'(1);
            end
            default: ;
         endcase
         if (last) begin
            state    <= FINISH;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= fin_result;
            overflow <= fin_ovf;
            error    <= fin_err;
         end
      end
   end
endmodule

// File: tb/tb_fixed_point_unit_seq.sv
// tb/tb_fixed_point_unit_seq.sv - directed self-checking bench for fixed_point_unit_seq
// Two instances share stimulus: saturating (dut) and wrapping (dut_wrap).
module tb_fixed_point_unit_seq;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  operation = 3'b000;
   logic [31:0] op1 = '0, op2 = '0;
   logic        busy, done, overflow, error;
   logic [31:0] result;
   logic        w_busy, w_done, w_overflow, w_error;
   logic [31:0] w_result;
   int          vectors = 0;
   int          miscompares = 0;
   int          lat;

   always #5 clk = ~clk;

   fixed_point_unit_seq #(.WIDTH(32), .FBITS(10), .MUL_WIDTH(16), .SATURATE(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .operand_1(op1), .operand_2(op2), .busy(busy), .done(done),
      .result(result), .overflow(overflow), .error(error));

   fixed_point_unit_seq #(.WIDTH(32), .FBITS(10), .MUL_WIDTH(16), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .operand_1(op1), .operand_2(op2), .busy(w_busy), .done(w_done),
      .result(w_result), .overflow(w_overflow), .error(w_error));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int l);
      @(negedge clk);
      start = 1'b1; operation = o; op1 = x; op2 = y;
      @(posedge clk); #1;
      start = 1'b0;
      l = 0;
      do begin
         @(posedge clk); #1;
         l++;
      end while (!done && l < 200);
   endtask

   initial begin
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_err", 32'(error), 32'd0);
      @(negedge clk); reset = 1'b1;

      run_op(3'b010, 32'h00000600, 32'h00000800, lat);
      check("mul_lat", 32'(lat), 32'd5);
      check("mul_res", result, 32'h00000C00);
      check("mul_ovf", 32'(overflow), 32'd0);
      run_op(3'b010, 32'hFFFFFA00, 32'h00000800, lat);
      check("mul_neg_res", result, 32'hFFFFF400);
      check("mul_neg_wrap", w_result, 32'hFFFFF400);

      run_op(3'b011, 32'h00001000, 32'h0, lat);
      check("sqrt_lat", 32'(lat), 32'd21);
      check("sqrt4_res", result, 32'h00000800);
      run_op(3'b011, 32'h00000800, 32'h0, lat);
      check("sqrt2_res", result, 32'h000005A8);
      run_op(3'b011, 32'h80000000, 32'h0, lat);
      check("sqrt_neg_lat", 32'(lat), 32'd21);
      check("sqrt_neg_res", result, 32'h0);
      check("sqrt_neg_err", 32'(error), 32'd1);

      run_op(3'b100, 32'h00000C00, 32'h00000800, lat);
      check("div_lat", 32'(lat), 32'd43);
      check("div_res", result, 32'h00000600);
      check("div_err", 32'(error), 32'd0);
      run_op(3'b100, 32'h00000400, 32'h0, lat);
      check("div0_lat", 32'(lat), 32'd43);
      check("div0_res", result, 32'h7FFFFFFF);
      check("div0_err", 32'(error), 32'd1);
      check("div0_wrap_res", w_result, 32'h0);

      run_op(3'b000, 32'h7FFFFFFF, 32'h00000001, lat);
      check("add_sat_res", result, 32'h7FFFFFFF);
      check("add_sat_ovf", 32'(overflow), 32'd1);
      check("add_wrap_res", w_result, 32'h80000000);
      check("add_wrap_ovf", 32'(w_overflow), 32'd1);
      run_op(3'b001, 32'h00000C00, 32'h00000600, lat);
      check("sub_lat", 32'(lat), 32'd1);
      check("sub_res", result, 32'h00000600);
      check("sub_ovf", 32'(overflow), 32'd0);

      run_op(3'b101, 32'h00000123, 32'h00000456, lat);
      check("ill_lat", 32'(lat), 32'd1);
      check("ill_res", result, 32'h0);
      check("ill_err", 32'(error), 32'd1);
      check("ill_ovf", 32'(overflow), 32'd0);

      // start pulsed while SQRT is busy must be ignored
      @(negedge clk);
      start = 1'b1; operation = 3'b011; op1 = 32'h00001000; op2 = 32'h0;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 5) begin
            start = 1'b1; operation = 3'b000; op1 = 32'h7; op2 = 32'h9;
         end else begin
            start = 1'b0;
         end
      end while (!done && lat < 200);
      start = 1'b0;
      check("hsk_sqrt_lat", 32'(lat), 32'd21);
      check("hsk_sqrt_res", result, 32'h00000800);

      // start held through the done cycle: back-to-back accept
      @(negedge clk);
      start = 1'b1; operation = 3'b000; op1 = 32'h00000400; op2 = 32'h00000800;
      @(posedge clk); #1;
      check("b2b_busy0", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("b2b_done1", 32'(done), 32'd1);
      check("b2b_busy1", 32'(busy), 32'd0);
      check("b2b_res1", result, 32'h00000C00);
      operation = 3'b001; op1 = 32'h00000C00; op2 = 32'h00000600;
      @(posedge clk); #1;
      check("b2b_busy2", 32'(busy), 32'd1);
      check("b2b_done2", 32'(done), 32'd0);
      start = 1'b0;
      @(posedge clk); #1;
      check("b2b_done3", 32'(done), 32'd1);
      check("b2b_res2", result, 32'h00000600);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; operation = 3'b100; op1 = 32'h00000C00; op2 = 32'h00000800;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      check("arst_pre_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_res", result, 32'h0);
      check("arst_ovf", 32'(overflow), 32'd0);
      check("arst_err", 32'(error), 32'd0);
      @(negedge clk); reset = 1'b1;
      run_op(3'b010, 32'h00000400, 32'h00000400, lat);
      check("post_rst_mul_lat", 32'(lat), 32'd5);
      check("post_rst_mul_res", result, 32'h00000400);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
